// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Brief    : Moore-FSM control unit for a multicycle RV32I core. Sequences
//            the shared ALU, memory port, register file and immediate
//            extender one instruction at a time, and decodes the ALU
//            operation and immediate format.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal
);

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] w_alu_op;
  logic       w_branch;
  logic       w_pc_update;

  // State register; reset returns to FETCH at once, even mid-instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: op and funct are stable after FETCH, so no latching.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          c_OP_LOAD,
          c_OP_STORE:  state_d = S_MEMADR;
          c_OP_RTYPE:  state_d = S_EXECUTER;
          c_OP_ITYPE:  state_d = S_EXECUTEI;
          c_OP_JAL:    state_d = S_JAL;
          c_OP_BRANCH: state_d = S_BEQ;
          c_OP_LUI:    state_d = S_LUI;
          default:     state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == c_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_LUI:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore datapath controls; anything not named for a state stays 0.
  always_comb begin
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    w_alu_op    = 2'b00;
    w_branch    = 1'b0;
    w_pc_update = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite     = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        w_pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA  = 2'b10;
        w_alu_op = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        w_alu_op = 2'b10;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        w_alu_op = 2'b01;
        w_branch = 1'b1;
      end
      S_LUI: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
      end
      S_TRAP:     illegal = 1'b1;
      default:    illegal = 1'b0;
    endcase
  end

  // funct3[0] flips the sense of zero, giving beq (000) and bne (001).
  assign PCWrite = w_pc_update | (w_branch & (zero ^ funct3[0]));

  // ALU decoder; only R-type (op[5]=1) may turn funct3 000 into a subtract.
  always_comb begin
    ALUControl = 3'b000;
    case (w_alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format follows op in every state.
  always_comb begin
    case (op)
      c_OP_STORE:  ImmSrc = 3'b001;
      c_OP_BRANCH: ImmSrc = 3'b010;
      c_OP_JAL:    ImmSrc = 3'b011;
      c_OP_LUI:    ImmSrc = 3'b100;
      default:     ImmSrc = 3'b000;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control unit for the multicycle RV32I core. It sequences the shared ALU, memory port, register file and the immediate extender through a Moore FSM, one instruction at a time.
- It decodes op, funct3 and funct7b5 into per-cycle datapath enables and mux selects.
- Supported subset: lw, sw, R-type ALU, I-type ALU, beq/bne, jal and lui.
- It also drives the extender's 3-bit immediate-format select.

Parameters:
- TRAP_ON_ILLEGAL, 1, 1: an illegal opcode parks the FSM in TRAP until reset. 0: an illegal opcode returns to FETCH (treated as a nop).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; forces state to FETCH
- op  input  7  Instr[6:0] from the instruction register
- funct3  input  3  Instr[14:12]
- funct7b5  input  1  Instr[30]
- zero  input  1  ALU zero flag
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  data memory write strobe
- IRWrite  output  1  instruction register and OldPC enable
- RegWrite  output  1  register file write enable
- ResultSrc  output  2  result select: 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- ALUSrcA  output  2  ALU A select: 00 PC, 01 OldPC, 10 rs1
- ALUSrcB  output  2  ALU B select: 00 rs2, 01 ImmExt, 10 constant 4
- ImmSrc  output  3  extender format: 000 I, 001 S, 010 B, 011 J, 100 U
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  output  1  high while in TRAP

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state: reset sets state = FETCH immediately, including mid-instruction.
  - With reset high, outputs equal the FETCH decode: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, all other outputs 0.
  - ImmSrc follows op; illegal=0.
- Output style: all outputs are combinational from the state (plus op/funct/zero). There are no output registers.
- Default outputs: every signal not listed for a state is 0.
- States and outputs (internal ALUOp and PCUpdate):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target precompute).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - LUI: ResultSrc=11, RegWrite=1.
  - TRAP: illegal=1, all enables 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - 0110111 -> LUI
    - otherwise -> TRAP (TRAP_ON_ILLEGAL=1) or FETCH (TRAP_ON_ILLEGAL=0)
  - MEMADR: op 0000011 -> MEMREAD, else -> MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER, EXECUTEI, JAL -> ALUWB -> FETCH.
  - BEQ -> FETCH; LUI -> FETCH.
  - TRAP -> TRAP.
- Latency in cycles: lw 5; sw, R, I, jal 4 each; beq/bne and lui 3.
- PCWrite = PCUpdate | (Branch & (zero ^ funct3[0])). This gives beq (funct3 000) and bne (funct3 001).
- ImmSrc is decoded from op in every state:
  - lw, I-ALU: 000
  - sw: 001
  - branch: 010
  - jal: 011
  - lui: 100
  - any other op: 000
- ALUControl:
  - ALUOp 00 -> add.
  - ALUOp 01 -> sub.
  - ALUOp 10, by funct3:
    - 000: sub iff (funct7b5 & op[5]), else add (addi never subtracts)
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - any other funct3 -> add
- Input stability: op and funct are stable from DECODE onward because IR is written only in FETCH. The controller does not latch them.

Test Plan:
- reset pulse mid-MEMREAD (asynchronous, between edges) -> same cycle shows IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, MemWrite=0; first state after release is FETCH.
- lw (op 0000011) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB in 5 cycles; AdrSrc=1 in MEMREAD; RegWrite=1 with ResultSrc=01 only in MEMWB; ImmSrc=000.
- sw (op 0100011) -> 4 cycles; MemWrite=1 exactly one cycle (MEMWRITE); ImmSrc=001; RegWrite never asserted.
- R-type funct3 000, funct7b5=1 -> ALUControl=001 in EXECUTER. addi (op 0010011, funct7b5=1) -> ALUControl=000. funct3 111 -> 010, 110 -> 011, 010 -> 101.
- beq with zero=1 -> PCWrite=1 in BEQ. beq with zero=0 -> PCWrite=0. bne (funct3 001) with zero=0 -> PCWrite=1. All take 3 cycles with ImmSrc=010.
- jal -> ImmSrc=011, PCWrite=1 in JAL, RegWrite=1 in ALUWB. lui -> ImmSrc=100, ResultSrc=11 with RegWrite=1 in LUI. op 1111111 -> illegal=1 held for 10+ cycles (TRAP_ON_ILLEGAL=1), or back to FETCH after DECODE (TRAP_ON_ILLEGAL=0).
